spi_arbiter: RTL
================

SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of requesters and slave chip-selects (2..8).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req  input  NUM_REQ  per-requester transfer request, level.
REQ-005 SHALL have port req_data  input  8*NUM_REQ  byte to send; requester i uses bits [8i+7:8i].
REQ-006 SHALL have port req_mode  input  2*NUM_REQ  SPI mode (CPOL,CPHA); requester i uses bits [2i+1:2i].
REQ-007 SHALL have port gnt  output  NUM_REQ  one-cycle accept pulse to the winning requester.
REQ-008 SHALL have port rsp_valid  output  NUM_REQ  one-cycle completion pulse to the owning requester.
REQ-009 SHALL have port rsp_data  output  8  received byte, valid while rsp_valid is nonzero.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port m_start  output  1  start pulse to spi_master.
REQ-012 SHALL have port m_data_to_send  output  8  spi_master transmit byte.
REQ-013 SHALL have port m_mode  output  2  spi_master mode.
REQ-014 SHALL have port m_done  input  1  spi_master completion.
REQ-015 SHALL have port m_data_received  input  8  spi_master received byte.
REQ-016 SHALL have port m_cs_n  input  1  spi_master chip-select.
REQ-017 SHALL have port cs_n_out  output  NUM_REQ  per-slave chip-select, active-low.

Function
REQ-018 SHALL implement states IDLE, LAUNCH, BUSY, RESP, GAP.
REQ-019 IDLE: if req is nonzero, SHALL pick a winner, register owner, the winner's data and mode, and go to LAUNCH next cycle; else stay.
REQ-020 LAUNCH: SHALL assert m_start and gnt[owner] for exactly this one cycle, then go to BUSY.
REQ-021 BUSY: SHALL hold m_data_to_send and m_mode stable; on m_done=1, SHALL register m_data_received into rsp_data and go to RESP.
REQ-022 RESP: SHALL assert rsp_valid[owner] for exactly one cycle, then go to GAP.
REQ-023 GAP: one idle cycle so spi_master returns to idle; SHALL update the priority pointer to owner and go to IDLE.
REQ-024 Latency: req seen in IDLE at cycle T -> m_start/gnt at T+1; m_done at cycle D -> rsp_valid at D+1; earliest next m_start at D+4.
REQ-025 Default arbitration SHALL be round-robin: search starts at pointer+1 modulo NUM_REQ; the first set req bit wins.
REQ-026 cs_n_out[owner] SHALL equal m_cs_n in LAUNCH, BUSY, RESP; all other cs_n_out bits, and all bits in IDLE/GAP, SHALL be 1.
REQ-027 Requester SHALL hold req, data and mode stable until gnt; req deasserted before IDLE sampling is simply not considered.
REQ-028 req[owner] still high after gnt SHALL be treated as a new request in the next IDLE arbitration.
REQ-029 m_done outside BUSY SHALL be ignored.
REQ-030 rsp_data SHALL hold its last value until the next RESP.
REQ-031 No timeout: BUSY SHALL wait indefinitely for m_done.

Reset
REQ-032 On rst, state SHALL be IDLE; gnt, rsp_valid, m_start = 0; rsp_data, m_data_to_send = 0x00; m_mode = 0; busy = 0; cs_n_out = all ones.
REQ-033 Pointer SHALL reset to NUM_REQ-1, so requester 0 has first priority.
REQ-034 rst mid-transfer SHALL abort with no rsp_valid pulse; spi_master shares rst.

Configuration
REQ-035 With SPI_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority: the lowest index wins and the pointer is unused.
REQ-036 Without SPI_ARB_FIXED_PRIO_EN, round-robin per REQ-025 SHALL apply.

Verification
REQ-037 req=0001, data0=0x3C, mode0=0, slave returns 0xA5 -> gnt=0001 one cycle, cs_n_out=1110 during transfer, rsp_valid=0001, rsp_data=0xA5.
REQ-038 req=1111 held for 4 transfers after reset, round-robin -> grant order 0,1,2,3; with SPI_ARB_FIXED_PRIO_EN -> 0,0,0,0.
REQ-039 req=0100, mode2=3 -> m_mode=3 and m_data_to_send=data2 through BUSY; cs_n_out=1011.
REQ-040 m_done pulsed in IDLE and LAUNCH -> no rsp_valid and no state change beyond the normal sequence.
REQ-041 rst asserted mid-BUSY -> next cycle IDLE, cs_n_out=1111, busy=0, no rsp_valid.
REQ-042 Back-to-back requests on req=0011 -> second m_start exactly 3 cycles after first rsp_valid.

Source files
------------

// File: rtl/spi_arbiter.sv
// Arbitrates NUM_REQ requesters onto one shared spi_master and routes its chip-select to the owner.
// Define SPI_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority; default build is round-robin.
module spi_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [2*NUM_REQ-1:0] req_mode,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [7:0]           rsp_data,
  output logic                 busy,
  output logic                 m_start,
  output logic [7:0]           m_data_to_send,
  output logic [1:0]           m_mode,
  input  logic                 m_done,
  input  logic [7:0]           m_data_received,
  input  logic                 m_cs_n,
  output logic [NUM_REQ-1:0]   cs_n_out
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [2:0] {IDLE, LAUNCH, BUSY, RESP, GAP} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] owner;
  logic [IW-1:0] win_idx;

`ifdef SPI_ARB_FIXED_PRIO_EN
  always_comb begin
    win_idx = '0;
    for (int k = NUM_REQ-1; k >= 0; k--)
      if (req[k]) win_idx = IW'(k);
  end
`else
  logic [IW-1:0] ptr;
  logic [IW:0]   cand;

  // Scan from the far end back toward ptr+1 so the nearest requester is assigned last and wins.
  always_comb begin
    win_idx = '0;
    cand    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (req[cand[IW-1:0]]) win_idx = cand[IW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)              ptr <= IW'(NUM_REQ-1);
    else if (state == GAP) ptr <= owner;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gnt       = '0;
    rsp_valid = '0;
    m_start   = 1'b0;
    cs_n_out  = '1;
    busy      = (state != IDLE);
    case (state)
      IDLE:   if (|req) state_nxt = LAUNCH;
      LAUNCH: begin
        m_start         = 1'b1;
        gnt[owner]      = 1'b1;
        cs_n_out[owner] = m_cs_n;
        state_nxt       = BUSY;
      end
      BUSY: begin
        cs_n_out[owner] = m_cs_n;
        if (m_done) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid[owner] = 1'b1;
        cs_n_out[owner]  = m_cs_n;
        state_nxt        = GAP;
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Owner's byte/mode are latched at arbitration so the master sees them stable through BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner          <= '0;
      m_data_to_send <= 8'h00;
      m_mode         <= 2'd0;
      rsp_data       <= 8'h00;
    end else begin
      if (state == IDLE && |req) begin
        owner          <= win_idx;
        m_data_to_send <= req_data[8*win_idx +: 8];
        m_mode         <= req_mode[2*win_idx +: 2];
      end
      if (state == BUSY && m_done) rsp_data <= m_data_received;
    end
  end

endmodule
